// File: rtl/uart_rx_ovs.sv
// rtl/uart_rx_ovs.sv - 16x oversampling UART receiver with error-flagged FWFT receive FIFO
module uart_rx_ovs #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_en_i,
    input  logic [DIV_W-1:0]            cfg_div_i,
    input  logic [1:0]                  cfg_dbits_i,
    input  logic [1:0]                  cfg_parity_i,
    input  logic                        cfg_stop2_i,
    input  logic                        rx_i,
    output logic [7:0]                  rx_data_o,
    output logic                        rx_perr_o,
    output logic                        rx_ferr_o,
    output logic                        rx_brk_o,
    output logic                        rx_valid_o,
    input  logic                        rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o,
    output logic                        overrun_o,
    input  logic                        overrun_clr_i
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t state, state_nx;

    logic sync1, sync2, hist, fall;
    always_ff @(posedge clk) begin
        if (rst || !cfg_en_i) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= rx_i;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end
    assign fall = hist & ~sync2;

    // Oversample tick; idle keeps the counter at zero so it restarts aligned to the start edge
    logic [DIV_W-1:0] tick_cnt;
    logic             tick;
    assign tick = (state != S_IDLE) && (tick_cnt == cfg_div_i);
    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE || tick) tick_cnt <= '0;
        else                                tick_cnt <= tick_cnt + DIV_W'(1);
    end

    logic [3:0] sub_cnt;
    logic       s7, s8, maj, at_mid, at_end;
    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE) begin
            sub_cnt <= 4'd0;
            s7      <= 1'b1;
            s8      <= 1'b1;
        end else if (tick) begin
            sub_cnt <= sub_cnt + 4'd1;
            if (sub_cnt == 4'd7) s7 <= sync2;
            if (sub_cnt == 4'd8) s8 <= sync2;
        end
    end
    assign maj    = (s7 & s8) | (s7 & sync2) | (s8 & sync2);
    assign at_mid = tick && (sub_cnt == 4'd9);
    assign at_end = tick && (sub_cnt == 4'd15);

    logic [2:0] bit_cnt;
    logic [7:0] data_r;
    logic       par_bit, stop0_r, ferr_r, stop_idx;
    logic       par_en, last_data, last_stop, push_req;
    assign par_en    = cfg_parity_i[0] ^ cfg_parity_i[1];
    assign last_data = (bit_cnt == ({1'b0, cfg_dbits_i} + 3'd4));
    assign last_stop = (stop_idx == cfg_stop2_i);

    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE) begin
            bit_cnt  <= 3'd0;
            data_r   <= 8'h00;
            par_bit  <= 1'b0;
            stop0_r  <= 1'b1;
            ferr_r   <= 1'b0;
            stop_idx <= 1'b0;
        end else if (tick) begin
            case (state)
                S_DATA: begin
                    if (sub_cnt == 4'd9)  data_r[bit_cnt] <= maj;
                    if (sub_cnt == 4'd15) bit_cnt <= bit_cnt + 3'd1;
                end
                S_PARITY: if (sub_cnt == 4'd9) par_bit <= maj;
                S_STOP: begin
                    if (sub_cnt == 4'd9) begin
                        if (!maj)      ferr_r  <= 1'b1;
                        if (!stop_idx) stop0_r <= maj;
                    end
                    if (sub_cnt == 4'd15) stop_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!cfg_en_i) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (fall) state_nx = S_START;
                S_START:  if (at_mid && maj) state_nx = S_IDLE;
                          else if (at_end) state_nx = S_DATA;
                S_DATA:   if (at_end && last_data) state_nx = par_en ? S_PARITY : S_STOP;
                S_PARITY: if (at_end) state_nx = S_STOP;
                S_STOP:   if (at_mid && last_stop) state_nx = S_IDLE;
                          else if (at_end) state_nx = S_STOP;
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        push_req = 1'b0;
        if (cfg_en_i && state == S_STOP && at_mid && last_stop) push_req = 1'b1;
    end

    // The last stop sample is still in flight at push time, so fold it in combinationally
    logic        stop0_now, ferr_now, perr_now, brk_now, exp_par;
    logic [10:0] entry;
    assign stop0_now = stop_idx ? stop0_r : maj;
    assign ferr_now  = ferr_r | ~maj;
    assign exp_par   = (^data_r) ^ cfg_parity_i[1];
    assign perr_now  = par_en & (par_bit != exp_par);
    assign brk_now   = (data_r == 8'h00) & ~(par_en & par_bit) & ~stop0_now;
    assign entry     = {brk_now, ferr_now, perr_now, data_r};

    logic [10:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             full, pop, do_push;
    assign full    = (cnt == CNT_W'(FIFO_DEPTH));
    assign pop     = rx_valid_o && rx_ready_i;
    assign do_push = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !pop)      cnt <= cnt + CNT_W'(1);
            else if (pop && !do_push) cnt <= cnt - CNT_W'(1);
            if (push_req && full && !pop) overrun_o <= 1'b1;
            else if (overrun_clr_i)       overrun_o <= 1'b0;
        end
    end

    logic [10:0] head;
    assign head       = mem[rd_ptr];
    assign rx_valid_o = (cnt != '0);
    assign fifo_cnt_o = cnt;
    assign rx_data_o  = rx_valid_o ? head[7:0] : 8'h00;
    assign rx_perr_o  = rx_valid_o & head[8];
    assign rx_ferr_o  = rx_valid_o & head[9];
    assign rx_brk_o   = rx_valid_o & head[10];
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb/tb_uart_rx_ovs.sv - randomized self-checking bench for uart_rx_ovs against a frame-level model
module tb_uart_rx_ovs;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, cfg_en, cfg_stop2, rx, rx_ready, overrun_clr;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_dbits, cfg_parity;
    logic [7:0]  rx_data;
    logic        rx_perr, rx_ferr, rx_brk, rx_valid, overrun;
    logic [2:0]  fifo_cnt;

    always #5 clk = ~clk;

    uart_rx_ovs #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_en_i(cfg_en), .cfg_div_i(cfg_div),
        .cfg_dbits_i(cfg_dbits), .cfg_parity_i(cfg_parity), .cfg_stop2_i(cfg_stop2),
        .rx_i(rx), .rx_data_o(rx_data), .rx_perr_o(rx_perr), .rx_ferr_o(rx_ferr),
        .rx_brk_o(rx_brk), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .fifo_cnt_o(fifo_cnt), .overrun_o(overrun), .overrun_clr_i(overrun_clr)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [10:0] exp_q[$];
    bit          model_ovr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int tick_clk();
        return int'(cfg_div) + 1;
    endfunction

    task automatic send_bit(input logic b);
        rx = b;
        wait_clk(16 * tick_clk());
    endtask

    // One-tick inverted pulse over the sampling window; exactly one of three samples sees it
    task automatic send_glitch_bit(input logic b);
        rx = b;
        wait_clk(8 * tick_clk());
        rx = ~b;
        wait_clk(tick_clk());
        rx = b;
        wait_clk(7 * tick_clk());
    endtask

    function automatic logic [10:0] expect_entry(input logic [7:0] d, input bit p, input bit s0, input bit s1);
        logic [7:0] m;
        bit pe, perr, ferr, brk;
        m    = d & (8'hFF >> (2'd3 - cfg_dbits));
        pe   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
        perr = pe && (p != ((^m) ^ (cfg_parity == 2'b10)));
        ferr = !s0 || (cfg_stop2 && !s1);
        brk  = (m == 8'h00) && (!pe || !p) && !s0;
        return {brk, ferr, perr, m};
    endfunction

    task automatic model_push(input logic [10:0] e);
        if (exp_q.size() == DEPTH) model_ovr = 1'b1;
        else                       exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit s0, input bit s1, input int glitch_bit);
        int         nb;
        bit         p;
        logic [7:0] m;
        nb = int'(cfg_dbits) + 5;
        m  = d & (8'hFF >> (2'd3 - cfg_dbits));
        p  = (^m) ^ (cfg_parity == 2'b10) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) begin
            if (i == glitch_bit) send_glitch_bit(d[i]);
            else                 send_bit(d[i]);
        end
        if (cfg_parity == 2'b01 || cfg_parity == 2'b10) send_bit(p);
        send_bit(s0);
        if (cfg_stop2) send_bit(s1);
        model_push(expect_entry(d, p, s0, s1));
        send_bit(1'b1);
    endtask

    task automatic configure(input int div, input logic [1:0] dbits, input logic [1:0] par, input logic stop2);
        cfg_en = 1'b0;
        wait_clk(2);
        cfg_div    = 16'(div);
        cfg_dbits  = dbits;
        cfg_parity = par;
        cfg_stop2  = stop2;
        wait_clk(1);
        cfg_en = 1'b1;
        wait_clk(4);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic [10:0] e;
        int          t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = 0;
            while (!rx_valid && t < 100) begin
                wait_clk(1);
                t++;
            end
            check({tag, "_valid"}, 32'(rx_valid), 32'd1);
            check({tag, "_entry"}, 32'({rx_brk, rx_ferr, rx_perr, rx_data}), 32'(e));
            pop_one();
        end
        check({tag, "_empty"}, 32'({rx_valid, fifo_cnt}), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        bit         bp, s0, s1;

        rst = 1'b1; cfg_en = 1'b0; rx = 1'b1; rx_ready = 1'b0; overrun_clr = 1'b0;
        cfg_div = 16'd3; cfg_dbits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        wait_clk(5);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_head", 32'({rx_brk, rx_ferr, rx_perr, rx_data}), 32'd0);
        check("rst_cnt", 32'(fifo_cnt), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        wait_clk(2);

        configure(3, 2'b11, 2'b00, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, -1);
        check("8n1_cnt", 32'(fifo_cnt), 32'd1);
        drain("8n1");

        configure(3, 2'b10, 2'b01, 1'b0);
        send_frame(8'h35, 1'b1, 1'b1, 1'b1, -1);
        send_frame(8'h35, 1'b0, 1'b1, 1'b1, -1);
        check("7e1_cnt", 32'(fifo_cnt), 32'd2);
        drain("7e1");

        configure(3, 2'b00, 2'b10, 1'b1);
        send_frame(8'h1F, 1'b0, 1'b1, 1'b0, -1);
        drain("5o2");

        configure(3, 2'b11, 2'b00, 1'b0);
        rx = 1'b0;
        wait_clk(5 * tick_clk());
        rx = 1'b1;
        wait_clk(32 * tick_clk());
        check("false_start_cnt", 32'(fifo_cnt), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, -1);
        drain("after_false");

        send_frame(8'h00, 1'b0, 1'b1, 1'b1, 3);
        drain("glitch");

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b1, -1);
        check("full_cnt", 32'(fifo_cnt), 32'(DEPTH));
        check("ovr_set", 32'(overrun), 32'(model_ovr));
        drain("depth");
        check("ovr_kept", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        wait_clk(1);
        overrun_clr = 1'b0;
        model_ovr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'(model_ovr));

        configure(3, 2'b11, 2'b01, 1'b0);
        rx = 1'b0;
        wait_clk(22 * 16 * tick_clk());
        exp_q.push_back({1'b1, 1'b1, 1'b0, 8'h00});
        check("brk_cnt", 32'(fifo_cnt), 32'd1);
        rx = 1'b1;
        wait_clk(32 * tick_clk());
        check("brk_only_one", 32'(fifo_cnt), 32'd1);
        drain("brk");
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, -1);
        drain("after_brk");

        configure(3, 2'b11, 2'b00, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        cfg_en = 1'b0;
        rx = 1'b1;
        wait_clk(4);
        cfg_en = 1'b1;
        wait_clk(32 * tick_clk());
        check("en_drop_cnt", 32'(fifo_cnt), 32'd0);

        for (int g = 0; g < 8; g++) begin
            configure($urandom_range(0, 3), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
            for (int f = 0; f < 3; f++) begin
                d  = 8'($urandom);
                bp = ($urandom_range(0, 4) == 0);
                s0 = ($urandom_range(0, 5) != 0);
                s1 = ($urandom_range(0, 5) != 0);
                send_frame(d, bp, s0, s1, -1);
            end
            check("rnd_cnt", 32'(fifo_cnt), 32'd3);
            drain("rnd");
        end
        check("final_ovr", 32'(overrun), 32'(model_ovr));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
